// File: rtl/da_filter_sequencer_pkg.sv
// Shared constants for the DA filter sequencer.
// State codes, phase vectors and default widths.
package da_filter_sequencer_pkg;

  localparam int DA_XW = 8;
  localparam int DA_RW = 11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_P1    = 3'd1;
  localparam logic [2:0] S_P2    = 3'd2;
  localparam logic [2:0] S_P3    = 3'd3;
  localparam logic [2:0] S_P4    = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_CLR   = 3'd6;

  localparam logic [5:0] T_IDLE  = 6'b010000;
  localparam logic [5:0] T_P1    = 6'b000001;
  localparam logic [5:0] T_P2    = 6'b000010;
  localparam logic [5:0] T_P3    = 6'b000100;
  localparam logic [5:0] T_P4    = 6'b001000;
  localparam logic [5:0] T_DRAIN = 6'b010000;
  localparam logic [5:0] T_CLR   = 6'b100000;

  // Phase vector seen by the datapath in each state.
  function automatic logic [5:0] phase_t(input logic [2:0] s);
    logic [5:0] v;
    v = T_IDLE;
    case (s)
      S_P1:    v = T_P1;
      S_P2:    v = T_P2;
      S_P3:    v = T_P3;
      S_P4:    v = T_P4;
      S_DRAIN: v = T_DRAIN;
      S_CLR:   v = T_CLR;
      default: v = T_IDLE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/da_filter_sequencer_result_buffer.sv
// One-entry result buffer for the DA filter.
// Resolves sum/carry and holds y until accepted.
module da_result_buffer
  import da_filter_sequencer_pkg::*;
#(
  parameter int RW = DA_RW
) (
  input  logic          clk,
  input  logic          r,
  input  logic          i_capture,
  input  logic [RW-1:0] i_sum,
  input  logic [RW-1:0] i_carry,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [RW-1:0] o_y
);

  logic [RW-1:0] w_y;

  // Carry-out past RW bits is dropped.
  assign w_y = i_sum + i_carry;

  // Capture wins over a same-edge drain.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      o_valid <= 1'b0;
      o_y     <= '0;
    end else if (i_capture) begin
      o_valid <= 1'b1;
      o_y     <= w_y;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/da_filter_sequencer.sv
// Sequencer for the 4-tap DA filter step.
// Runs P1..P4, DRAIN, CLR and holds operands.
module da_filter_sequencer
  import da_filter_sequencer_pkg::*;
#(
  parameter int XW = DA_XW,
  parameter int RW = DA_RW
) (
  input  logic          clk,
  input  logic          r,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x1_in,
  input  logic [XW-1:0] x2_in,
  input  logic [XW-1:0] x3_in,
  input  logic [XW-1:0] x4_in,
  output logic [XW-1:0] x1,
  output logic [XW-1:0] x2,
  output logic [XW-1:0] x3,
  output logic [XW-1:0] x4,
  output logic [5:0]    t,
  input  logic [RW-1:0] dp_sum,
  input  logic [RW-1:0] dp_carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] y,
  output logic          busy
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_armed;
  logic       w_accept;
  logic       w_free;
  logic       w_capture;

  assign in_ready  = r_armed && (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_free    = !out_valid || out_ready;
  assign w_capture = (r_state == S_DRAIN) && w_free;
  assign busy      = (r_state != S_IDLE);
  assign t         = phase_t(r_state);

  // Next-state: fixed phase walk, DRAIN waits for buffer space.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_P1 : S_IDLE;
      S_P1:    w_next = S_P2;
      S_P2:    w_next = S_P3;
      S_P3:    w_next = S_P4;
      S_P4:    w_next = S_DRAIN;
      S_DRAIN: w_next = w_free ? S_CLR : S_DRAIN;
      S_CLR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Holds in_ready low for the first cycle after reset.
  always_ff @(posedge clk or negedge r) begin
    if (!r) r_armed <= 1'b0;
    else    r_armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge r) begin
    if (!r) r_state <= S_IDLE;
    else    r_state <= w_next;
  end

  // Operands change only on an accept edge.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      x4 <= '0;
    end else if (w_accept) begin
      x1 <= x1_in;
      x2 <= x2_in;
      x3 <= x3_in;
      x4 <= x4_in;
    end
  end

  da_result_buffer #(
    .RW(RW)
  ) u_buf (
    .clk       (clk),
    .r         (r),
    .i_capture (w_capture),
    .i_sum     (dp_sum),
    .i_carry   (dp_carry),
    .i_ready   (out_ready),
    .o_valid   (out_valid),
    .o_y       (y)
  );

endmodule

// File: tb/tb_da_filter_sequencer.sv
// Directed bench for da_filter_sequencer.
// Inputs driven and outputs sampled on negedge.
module tb_da_filter_sequencer;

  logic        clk;
  logic        r;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x1_in, x2_in, x3_in, x4_in;
  logic [7:0]  x1, x2, x3, x4;
  logic [5:0]  t;
  logic [10:0] dp_sum, dp_carry;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] y;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc;
  logic [31:0] exp_x;
  logic [5:0]  tseq [6];

  da_filter_sequencer dut (
    .clk       (clk),
    .r         (r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1_in     (x1_in),
    .x2_in     (x2_in),
    .x3_in     (x3_in),
    .x4_in     (x4_in),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .x4        (x4),
    .t         (t),
    .dp_sum    (dp_sum),
    .dp_carry  (dp_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd_in;
    x1_in = 8'($urandom);
    x2_in = 8'($urandom);
    x3_in = 8'($urandom);
    x4_in = 8'($urandom);
  endtask

  // Accept one sample set; returns at the P1 negedge.
  task automatic start_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    x1_in = a; x2_in = b; x3_in = c; x4_in = d;
    exp_x = {a, b, c, d};
    in_valid = 1'b1;
    chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("t_p1", {26'd0, t}, {26'd0, tseq[0]});
    chk("busy_p1", {31'd0, busy}, 32'd1);
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic run_phases(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rnd_in;
      tick;
      chk($sformatf("t_ph%0d", i), {26'd0, t}, {26'd0, tseq[i]});
    end
  endtask

  // Operands must equal the accepted set whenever busy.
  always @(negedge clk) begin
    if (r && busy)
      chk("x_stable", {x1, x2, x3, x4}, exp_x);
  end

  initial begin
    tseq[0] = 6'b000001;
    tseq[1] = 6'b000010;
    tseq[2] = 6'b000100;
    tseq[3] = 6'b001000;
    tseq[4] = 6'b010000;
    tseq[5] = 6'b100000;
    r = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x1_in = '0; x2_in = '0; x3_in = '0; x4_in = '0;
    dp_sum = '0; dp_carry = '0;
    exp_x = '0;

    @(negedge clk);
    chk("rst_t", {26'd0, t}, 32'h10);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_y", {21'd0, y}, 32'd0);
    chk("rst_x", {x1, x2, x3, x4}, 32'd0);
    r = 1'b1;
    chk("rel_in_ready0", {31'd0, in_ready}, 32'd0);
    tick;
    chk("rel_in_ready1", {31'd0, in_ready}, 32'd1);

    // Single transaction.
    dp_sum = 11'h010; dp_carry = 11'h005; out_ready = 1'b1;
    start_txn(8'h05, 8'h00, 8'h00, 8'h00);
    run_phases(1, 4);
    chk("lat_ov_drain", {31'd0, out_valid}, 32'd0);
    run_phases(5, 5);
    chk("single_ov", {31'd0, out_valid}, 32'd1);
    chk("single_y", {21'd0, y}, 32'h015);
    tick;
    chk("single_ov_clr", {31'd0, out_valid}, 32'd0);
    chk("single_idle_t", {26'd0, t}, 32'h10);
    chk("single_in_ready", {31'd0, in_ready}, 32'd1);

    // Wrap, result left pending.
    dp_sum = 11'h7FF; dp_carry = 11'h002; out_ready = 1'b0;
    start_txn(8'h81, 8'h7F, 8'h00, 8'hFF);
    run_phases(1, 5);
    chk("wrap_ov", {31'd0, out_valid}, 32'd1);
    chk("wrap_y", {21'd0, y}, 32'h001);
    tick;
    chk("wrap_hold_ov", {31'd0, out_valid}, 32'd1);
    chk("wrap_hold_y", {21'd0, y}, 32'h001);

    // Asynchronous reset in P3.
    dp_sum = 11'h003; dp_carry = 11'h004;
    start_txn(8'h12, 8'h34, 8'h56, 8'h78);
    run_phases(1, 2);
    #2 r = 1'b0;
    #1;
    chk("arst_t", {26'd0, t}, 32'h10);
    chk("arst_ov", {31'd0, out_valid}, 32'd0);
    chk("arst_y", {21'd0, y}, 32'd0);
    chk("arst_x", {x1, x2, x3, x4}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    r = 1'b1;
    chk("arel_in_ready0", {31'd0, in_ready}, 32'd0);
    tick;
    chk("arel_in_ready1", {31'd0, in_ready}, 32'd1);

    // Backpressure: second result stalls in DRAIN.
    out_ready = 1'b0;
    dp_sum = 11'h100; dp_carry = 11'h023;
    start_txn(8'h01, 8'h02, 8'h03, 8'h04);
    run_phases(1, 5);
    chk("bp_a_y", {21'd0, y}, 32'h123);
    tick;
    chk("bp_a_ov_idle", {31'd0, out_valid}, 32'd1);
    dp_sum = 11'h200; dp_carry = 11'h001;
    start_txn(8'h09, 8'h08, 8'h07, 8'h06);
    run_phases(1, 4);
    for (int i = 0; i < 3; i++) begin
      rnd_in;
      tick;
      chk("bp_stall_t", {26'd0, t}, 32'h10);
      chk("bp_stall_y", {21'd0, y}, 32'h123);
      chk("bp_stall_ov", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick;
    chk("bp_clr_t", {26'd0, t}, 32'h20);
    chk("bp_b_y", {21'd0, y}, 32'h201);
    chk("bp_b_ov", {31'd0, out_valid}, 32'd1);
    tick;
    chk("bp_b_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_t", {26'd0, t}, 32'h10);

    // Continuous in_valid: one accept per 7 cycles.
    n_acc = 0;
    x1_in = 8'h33; x2_in = 8'h00; x3_in = 8'h00; x4_in = 8'h00;
    in_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k >= 1) x1_in = 8'hAA;
      if (busy) begin
        x2_in = 8'($urandom);
        x3_in = 8'($urandom);
        x4_in = 8'($urandom);
      end
      if (in_ready) begin
        n_acc++;
        exp_x = {x1_in, x2_in, x3_in, x4_in};
      end
      if (k >= 1 && k <= 6)
        chk("ign_x1", {24'd0, x1}, 32'h33);
      tick;
    end
    in_valid = 1'b0;
    chk("ign_accepts", n_acc, 32'd2);
    chk("ign_x1_next", {24'd0, x1}, 32'hAA);
    chk("ign_end_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
